// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// A launched mult/multu/div/divu computes its result into temporaries at
// the launch edge, then holds Busy for a fixed number of cycles before
// committing to HI/LO. mthi/mtlo write HI/LO directly when idle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        OutSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_N   = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N    = CNT_W'(DIV_CYCLES);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      tmp_hi_r;
    logic [31:0]      tmp_lo_r;
    logic             tmp_wr_r;

    logic             idle_s;
    logic             launch_s;
    logic             commit_s;
    logic [CNT_W-1:0] load_n_s;

    logic signed [63:0] a_ext_s;
    logic signed [63:0] b_ext_s;
    logic        [63:0] sprod_s;
    logic        [63:0] uprod_s;
    logic        [31:0] a_mag_s;
    logic        [31:0] b_mag_s;
    logic        [31:0] b_mag_safe_s;
    logic        [31:0] sq_mag_s;
    logic        [31:0] sr_mag_s;
    logic        [31:0] b_safe_s;
    logic        [31:0] uq_s;
    logic        [31:0] ur_s;
    logic        [31:0] res_hi_s;
    logic        [31:0] res_lo_s;
    logic               res_wr_s;

    // Launch/commit decode and per-op busy length.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        launch_s = 1'b0;
        load_n_s = DIV_N;
        commit_s = (state_r == ST_RUN) && (cnt_r <= CNT_ONE);
        if (idle_s && Start && !Req &&
            ((MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
             (MDOp == OP_DIV)  || (MDOp == OP_DIVU))) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
        if ((MDOp == OP_MULT) || (MDOp == OP_MULTU)) begin
            load_n_s = MULT_N;
        end else begin
            load_n_s = DIV_N;
        end
    end

    // Arithmetic datapath: signed division works on magnitudes and re-applies
    // signs, so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    // Zero divisors are replaced by 1 to keep the dividers defined; their
    // result is discarded via res_wr_s.
    always_comb begin
        a_ext_s      = {{32{A[31]}}, A};
        b_ext_s      = {{32{B[31]}}, B};
        sprod_s      = a_ext_s * b_ext_s;
        uprod_s      = {32'h0, A} * {32'h0, B};
        a_mag_s      = A[31] ? (32'h0 - A) : A;
        b_mag_s      = B[31] ? (32'h0 - B) : B;
        b_mag_safe_s = (b_mag_s == 32'h0) ? 32'h1 : b_mag_s;
        sq_mag_s     = a_mag_s / b_mag_safe_s;
        sr_mag_s     = a_mag_s % b_mag_safe_s;
        b_safe_s     = (B == 32'h0) ? 32'h1 : B;
        uq_s         = A / b_safe_s;
        ur_s         = A % b_safe_s;
        res_hi_s     = 32'h0;
        res_lo_s     = 32'h0;
        res_wr_s     = 1'b0;
        case (MDOp)
            OP_MULT: begin
                res_hi_s = sprod_s[63:32];
                res_lo_s = sprod_s[31:0];
                res_wr_s = 1'b1;
            end
            OP_MULTU: begin
                res_hi_s = uprod_s[63:32];
                res_lo_s = uprod_s[31:0];
                res_wr_s = 1'b1;
            end
            OP_DIV: begin
                res_lo_s = (A[31] ^ B[31]) ? (32'h0 - sq_mag_s) : sq_mag_s;
                res_hi_s = A[31] ? (32'h0 - sr_mag_s) : sr_mag_s;
                res_wr_s = (B != 32'h0);
            end
            OP_DIVU: begin
                res_lo_s = uq_s;
                res_hi_s = ur_s;
                res_wr_s = (B != 32'h0);
            end
            default: begin
                res_hi_s = 32'h0;
                res_lo_s = 32'h0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Control FSM: IDLE -> RUN on launch, count down, back to IDLE on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (launch_s) begin
                state_r <= ST_RUN;
                cnt_r   <= load_n_s;
                busy_r  <= 1'b1;
            end else begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                busy_r  <= 1'b0;
            end
        end else begin
            if (commit_s) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                busy_r  <= 1'b0;
            end else begin
                state_r <= ST_RUN;
                cnt_r   <= cnt_r - CNT_ONE;
                busy_r  <= 1'b1;
            end
        end
    end

    // Result temporaries captured at launch and held through RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmp_hi_r <= 32'h0;
            tmp_lo_r <= 32'h0;
            tmp_wr_r <= 1'b0;
        end else if (launch_s) begin
            tmp_hi_r <= res_hi_s;
            tmp_lo_r <= res_lo_s;
            tmp_wr_r <= res_wr_s;
        end else begin
            tmp_hi_r <= tmp_hi_r;
            tmp_lo_r <= tmp_lo_r;
            tmp_wr_r <= tmp_wr_r;
        end
    end

    // Architectural HI/LO: committed results or direct mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'h0;
            lo_r <= 32'h0;
        end else if (commit_s) begin
            if (tmp_wr_r) begin
                hi_r <= tmp_hi_r;
                lo_r <= tmp_lo_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else if (idle_s && !Req && (MDOp == OP_MTHI)) begin
            hi_r <= A;
        end else if (idle_s && !Req && (MDOp == OP_MTLO)) begin
            lo_r <= A;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign Busy  = busy_r;
    assign HI    = hi_r;
    assign LO    = lo_r;
    assign MDOut = OutSel ? lo_r : hi_r;

endmodule
